// File: rtl/stack_seq.sv
// Memory-stage stack sequencer: runs the multi-cycle push/pop/vector-fetch work for
// CALL, RET, RTI and interrupts, owns SP, and hands the resulting PC back to fetch.
module stack_seq #(
    parameter int            AW       = 11,
    parameter logic [AW-1:0] SP_RESET = {AW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          INT,
    input  logic          Call,
    input  logic          Ret,
    input  logic          Rti,
    input  logic [31:0]   PcIn,
    input  logic [31:0]   CallTarget,
    input  logic [2:0]    FlagsIn,
    input  logic [15:0]   MemRdData,
    output logic [AW-1:0] MemAddr,
    output logic [15:0]   MemWrData,
    output logic          MemWE,
    output logic          MemRE,
    output logic          Busy,
    output logic [31:0]   PcOut,
    output logic          PcLoad,
    output logic [2:0]    FlagsOut,
    output logic          FlagsLoad,
    output logic [AW-1:0] SP
);

    typedef enum logic [3:0] {
        IDLE, PUSH_H, PUSH_L, PUSH_F, VEC_H, VEC_L, POP_F, POP_L, POP_H, FIN
    } state_t;

    typedef enum logic [1:0] {K_INT, K_CALL, K_RET, K_RTI} kind_t;

    localparam logic [AW-1:0] SP_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state, state_nx;
    kind_t         kind, kind_nx;
    logic [AW-1:0] sp, sp_inc, sp_dec;
    logic          pending;
    logic          accept;
    logic [31:0]   pc_q, tgt_q;
    logic [2:0]    flags_in_q, flags_rd_q;
    logic [15:0]   word_q;

    assign sp_inc = sp + SP_ONE;
    assign sp_dec = sp - SP_ONE;
    assign accept = (state == IDLE) && (state_nx != IDLE);
    assign Busy   = (state != IDLE);
    assign SP     = sp;

    // Request arbitration happens only in IDLE; a pending interrupt counts as INT.
    always_comb begin
        state_nx = state;
        kind_nx  = K_INT;
        case (state)
            IDLE: begin
                if (INT || pending) begin
                    state_nx = PUSH_H;
                    kind_nx  = K_INT;
                end else if (Call) begin
                    state_nx = PUSH_H;
                    kind_nx  = K_CALL;
                end else if (Rti) begin
                    state_nx = POP_F;
                    kind_nx  = K_RTI;
                end else if (Ret) begin
                    state_nx = POP_L;
                    kind_nx  = K_RET;
                end
            end
            PUSH_H:  state_nx = PUSH_L;
            PUSH_L:  state_nx = (kind == K_INT) ? PUSH_F : FIN;
            PUSH_F:  state_nx = VEC_H;
            VEC_H:   state_nx = VEC_L;
            VEC_L:   state_nx = FIN;
            POP_F:   state_nx = POP_L;
            POP_L:   state_nx = POP_H;
            POP_H:   state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sp      <= SP_RESET;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (INT && (state != IDLE))
                pending <= 1'b1;
            else if (accept)
                pending <= 1'b0;
            case (state)
                PUSH_H, PUSH_L, PUSH_F: sp <= sp_dec;
                POP_F, POP_L, POP_H:    sp <= sp_inc;
                default:                ;
            endcase
        end
    end

    // NOTE: payload registers carry no reset; they are only read in states reached after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            kind       <= kind_nx;
            pc_q       <= PcIn;
            tgt_q      <= CallTarget;
            flags_in_q <= FlagsIn;
        end
        // Read data lags MemRE by one cycle, so each state captures the previous read.
        if ((state == VEC_L) || (state == POP_H))
            word_q <= MemRdData;
        if (state == POP_L)
            flags_rd_q <= MemRdData[2:0];
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        MemAddr   = '0;
        MemWrData = '0;
        MemWE     = 1'b0;
        MemRE     = 1'b0;
        PcOut     = '0;
        PcLoad    = 1'b0;
        FlagsOut  = '0;
        FlagsLoad = 1'b0;
        case (state)
            PUSH_H: begin
                MemWE     = 1'b1;
                MemAddr   = sp;
                MemWrData = pc_q[31:16];
            end
            PUSH_L: begin
                MemWE     = 1'b1;
                MemAddr   = sp;
                MemWrData = pc_q[15:0];
            end
            PUSH_F: begin
                MemWE     = 1'b1;
                MemAddr   = sp;
                MemWrData = {13'b0, flags_in_q};
            end
            VEC_H: begin
                MemRE   = 1'b1;
                MemAddr = '0;
            end
            VEC_L: begin
                MemRE   = 1'b1;
                MemAddr = SP_ONE;
            end
            POP_F, POP_L, POP_H: begin
                MemRE   = 1'b1;
                MemAddr = sp_inc;
            end
            FIN: begin
                PcLoad = 1'b1;
                case (kind)
                    K_INT:   PcOut = {word_q, MemRdData};
                    K_CALL:  PcOut = tgt_q;
                    default: PcOut = {MemRdData, word_q};
                endcase
                if (kind == K_RTI) begin
                    FlagsLoad = 1'b1;
                    FlagsOut  = flags_rd_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq: stimulus queues expected memory traffic and PC loads,
// monitors pop and compare whenever the DUTs present writes, reads or PcLoad.
module tb_stack_seq;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic [2:0]  flags;
        int          cyc;
    } pc_t;

    logic        clk = 1'b0;
    logic        rst, rst_w;
    logic        int_req, call_req, ret_req, rti_req;
    logic [31:0] pc_in, call_tgt;
    logic [2:0]  flags_in;
    logic [15:0] mem_rd_data;
    logic [10:0] mem_addr, sp;
    logic [15:0] mem_wr_data;
    logic        mem_we, mem_re, busy, pc_load, flags_load;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;

    logic        w_call;
    logic [31:0] w_pc, w_tgt;
    logic [10:0] w_addr, w_sp;
    logic [15:0] w_wr_data;
    logic        w_we, w_re, w_busy, w_pc_load, w_flags_load;
    logic [31:0] w_pc_out;
    logic [2:0]  w_flags_out;

    logic [15:0] mem [2048];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    wr_t         exp_wr[$];
    logic [10:0] exp_rd[$];
    pc_t         exp_pc[$];
    wr_t         exp_w_wr[$];
    pc_t         exp_w_pc[$];

    wr_t         mon_wr, mon_w_wr;
    pc_t         mon_pc, mon_w_pc;
    logic [10:0] mon_rd;

    stack_seq dut (
        .clk(clk), .rst(rst), .INT(int_req), .Call(call_req), .Ret(ret_req), .Rti(rti_req),
        .PcIn(pc_in), .CallTarget(call_tgt), .FlagsIn(flags_in), .MemRdData(mem_rd_data),
        .MemAddr(mem_addr), .MemWrData(mem_wr_data), .MemWE(mem_we), .MemRE(mem_re),
        .Busy(busy), .PcOut(pc_out), .PcLoad(pc_load), .FlagsOut(flags_out),
        .FlagsLoad(flags_load), .SP(sp)
    );

    stack_seq #(.AW(11), .SP_RESET(11'd0)) dut_w (
        .clk(clk), .rst(rst_w), .INT(1'b0), .Call(w_call), .Ret(1'b0), .Rti(1'b0),
        .PcIn(w_pc), .CallTarget(w_tgt), .FlagsIn(3'b000), .MemRdData(16'h0000),
        .MemAddr(w_addr), .MemWrData(w_wr_data), .MemWE(w_we), .MemRE(w_re),
        .Busy(w_busy), .PcOut(w_pc_out), .PcLoad(w_pc_load), .FlagsOut(w_flags_out),
        .FlagsLoad(w_flags_load), .SP(w_sp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: one-cycle read latency; vector table holds 0x0000_0200.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
            mem[1]      <= 16'h0200;
            mem_rd_data <= 16'h0000;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wr_data;
            if (mem_re) mem_rd_data <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_event(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic exp_write(input logic [10:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic exp_load(input logic [31:0] pc, input logic fl, input logic [2:0] f, input int c);
        pc_t e;
        e.pc    = pc;
        e.fl    = fl;
        e.flags = f;
        e.cyc   = c;
        exp_pc.push_back(e);
    endtask

    task automatic do_req(input logic i, input logic c, input logic r, input logic t,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] fl,
                          output int c0);
        @(negedge clk);
        int_req  = i;
        call_req = c;
        ret_req  = r;
        rti_req  = t;
        pc_in    = pc;
        call_tgt = tgt;
        flags_in = fl;
        @(posedge clk);
        #1;
        c0       = cyc;
        int_req  = 1'b0;
        call_req = 1'b0;
        ret_req  = 1'b0;
        rti_req  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) flag_event({name, "_timeout"});
    endtask

    // Main DUT monitor.
    always @(negedge clk) begin
        if (mem_we && mem_re) flag_event("we_re_overlap");
        if (mem_we) begin
            if (exp_wr.size() == 0) flag_event("write_unexpected");
            else begin
                mon_wr = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_wr.addr));
                check("wr_data", 32'(mem_wr_data), 32'(mon_wr.data));
            end
        end
        if (mem_re) begin
            if (exp_rd.size() == 0) flag_event("read_unexpected");
            else begin
                mon_rd = exp_rd.pop_front();
                check("rd_addr", 32'(mem_addr), 32'(mon_rd));
            end
        end
        if (flags_load && !pc_load) flag_event("flags_load_alone");
        if (pc_load) begin
            if (exp_pc.size() == 0) flag_event("pc_load_unexpected");
            else begin
                mon_pc = exp_pc.pop_front();
                check("pc_out", pc_out, mon_pc.pc);
                check("pc_load_cycle", 32'(cyc), 32'(mon_pc.cyc));
                check("flags_load", 32'(flags_load), 32'(mon_pc.fl));
                if (mon_pc.fl) check("flags_out", 32'(flags_out), 32'(mon_pc.flags));
            end
        end
    end

    // Wrap-instance monitor.
    always @(negedge clk) begin
        if (w_re) flag_event("w_read_unexpected");
        if (w_flags_load) flag_event("w_flags_load_unexpected");
        if (w_we) begin
            if (exp_w_wr.size() == 0) flag_event("w_write_unexpected");
            else begin
                mon_w_wr = exp_w_wr.pop_front();
                check("w_wr_addr", 32'(w_addr), 32'(mon_w_wr.addr));
                check("w_wr_data", 32'(w_wr_data), 32'(mon_w_wr.data));
            end
        end
        if (w_pc_load) begin
            if (exp_w_pc.size() == 0) flag_event("w_pc_load_unexpected");
            else begin
                mon_w_pc = exp_w_pc.pop_front();
                check("w_pc_out", w_pc_out, mon_w_pc.pc);
                check("w_pc_load_cycle", 32'(cyc), 32'(mon_w_pc.cyc));
                check("w_flags_out", 32'(w_flags_out), 32'(mon_w_pc.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  c0;
        wr_t we;
        pc_t pe;
        rst = 1'b1; rst_w = 1'b1;
        int_req = 1'b0; call_req = 1'b0; ret_req = 1'b0; rti_req = 1'b0;
        pc_in = '0; call_tgt = '0; flags_in = '0;
        w_call = 1'b0; w_pc = '0; w_tgt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst_w = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sp", 32'(sp), 32'd2047);
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_mem_en", 32'({mem_we, mem_re}), 32'd0);
        check("rst_flags_load", 32'(flags_load), 32'd0);
        check("rst_w_sp", 32'(w_sp), 32'd0);

        // CALL: push 0x0001_2345, jump to 0x100.
        exp_write(11'd2047, 16'h0001);
        exp_write(11'd2046, 16'h2345);
        do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_2345, 32'h0000_0100, 3'b000, c0);
        check("call_busy", 32'(busy), 32'd1);
        exp_load(32'h0000_0100, 1'b0, 3'b000, c0 + 2);
        wait_idle("call");
        check("call_sp", 32'(sp), 32'd2045);

        // RET: pop 2046 then 2047.
        exp_rd.push_back(11'd2046);
        exp_rd.push_back(11'd2047);
        do_req(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, c0);
        exp_load(32'h0001_2345, 1'b0, 3'b000, c0 + 2);
        wait_idle("ret");
        check("ret_sp", 32'(sp), 32'd2047);

        // INT: push PC and flags, fetch vector 0x0000_0200.
        exp_write(11'd2047, 16'h0000);
        exp_write(11'd2046, 16'h0010);
        exp_write(11'd2045, 16'h0005);
        exp_rd.push_back(11'd0);
        exp_rd.push_back(11'd1);
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 3'b101, c0);
        exp_load(32'h0000_0200, 1'b0, 3'b000, c0 + 5);
        wait_idle("int");
        check("int_sp", 32'(sp), 32'd2044);

        // RTI: restores flags 101 and PC 0x10.
        exp_rd.push_back(11'd2045);
        exp_rd.push_back(11'd2046);
        exp_rd.push_back(11'd2047);
        do_req(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, c0);
        exp_load(32'h0000_0010, 1'b1, 3'b101, c0 + 3);
        wait_idle("rti");
        check("rti_sp", 32'(sp), 32'd2047);

        // INT and CALL together: INT wins, CallTarget never loaded.
        exp_write(11'd2047, 16'h0003);
        exp_write(11'd2046, 16'h0004);
        exp_write(11'd2045, 16'h0002);
        exp_rd.push_back(11'd0);
        exp_rd.push_back(11'd1);
        do_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h0003_0004, 32'h0000_DEAD, 3'b010, c0);
        exp_load(32'h0000_0200, 1'b0, 3'b000, c0 + 5);
        wait_idle("int_call");
        check("int_call_sp", 32'(sp), 32'd2044);
        exp_rd.push_back(11'd2045);
        exp_rd.push_back(11'd2046);
        exp_rd.push_back(11'd2047);
        do_req(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, c0);
        exp_load(32'h0003_0004, 1'b1, 3'b010, c0 + 3);
        wait_idle("rti2");

        // INT pulse during CALL: pending INT runs after one IDLE cycle.
        exp_write(11'd2047, 16'h0000);
        exp_write(11'd2046, 16'h0AAA);
        exp_write(11'd2045, 16'h0000);
        exp_write(11'd2044, 16'h0500);
        exp_write(11'd2043, 16'h0001);
        exp_rd.push_back(11'd0);
        exp_rd.push_back(11'd1);
        do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0AAA, 32'h0000_0500, 3'b000, c0);
        exp_load(32'h0000_0500, 1'b0, 3'b000, c0 + 2);
        exp_load(32'h0000_0200, 1'b0, 3'b000, c0 + 9);
        @(posedge clk);
        #1;
        int_req  = 1'b1;
        pc_in    = 32'h0000_0500;
        flags_in = 3'b001;
        @(posedge clk);
        #1;
        int_req = 1'b0;
        repeat (10) @(posedge clk);
        wait_idle("pending_int");
        check("pending_sp", 32'(sp), 32'd2042);
        repeat (3) @(negedge clk);
        check("pending_cleared", 32'(busy), 32'd0);

        exp_rd.push_back(11'd2043);
        exp_rd.push_back(11'd2044);
        exp_rd.push_back(11'd2045);
        do_req(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, c0);
        exp_load(32'h0000_0500, 1'b1, 3'b001, c0 + 3);
        wait_idle("rti3");
        exp_rd.push_back(11'd2046);
        exp_rd.push_back(11'd2047);
        do_req(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, c0);
        exp_load(32'h0000_0AAA, 1'b0, 3'b000, c0 + 2);
        wait_idle("ret2");
        check("restored_sp", 32'(sp), 32'd2047);

        // Pop wrap: SP 2047 reads addresses 0 and 1, ends at 1.
        exp_rd.push_back(11'd0);
        exp_rd.push_back(11'd1);
        do_req(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, c0);
        exp_load(32'h0200_0000, 1'b0, 3'b000, c0 + 2);
        wait_idle("ret_wrap");
        check("pop_wrap_sp", 32'(sp), 32'd1);

        // Push wrap on the SP_RESET=0 instance.
        we.addr = 11'd0;    we.data = 16'h0007; exp_w_wr.push_back(we);
        we.addr = 11'd2047; we.data = 16'h7777; exp_w_wr.push_back(we);
        @(negedge clk);
        w_call = 1'b1; w_pc = 32'h0007_7777; w_tgt = 32'h0000_0040;
        @(posedge clk);
        #1;
        c0 = cyc;
        w_call = 1'b0;
        pe.pc = 32'h0000_0040; pe.fl = 1'b0; pe.flags = 3'b000; pe.cyc = c0 + 2;
        exp_w_pc.push_back(pe);
        repeat (4) @(negedge clk);
        check("w_wrap_sp", 32'(w_sp), 32'd2046);
        check("w_idle", 32'(w_busy), 32'd0);

        // Reset during PUSH_L aborts the second CALL.
        we.addr = 11'd2046; we.data = 16'h0001; exp_w_wr.push_back(we);
        we.addr = 11'd2045; we.data = 16'h1111; exp_w_wr.push_back(we);
        @(negedge clk);
        w_call = 1'b1; w_pc = 32'h0001_1111; w_tgt = 32'h0000_0080;
        @(posedge clk);
        #1;
        w_call = 1'b0;
        @(posedge clk);
        #1;
        rst_w = 1'b1;
        @(posedge clk);
        #1;
        check("w_abort_busy", 32'(w_busy), 32'd0);
        check("w_abort_sp", 32'(w_sp), 32'd0);
        check("w_abort_we", 32'(w_we), 32'd0);
        rst_w = 1'b0;
        repeat (5) @(negedge clk);
        check("w_abort_idle", 32'(w_busy), 32'd0);

        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("pc_queue_drained", 32'(exp_pc.size()), 32'd0);
        check("w_wr_queue_drained", 32'(exp_w_wr.size()), 32'd0);
        check("w_pc_queue_drained", 32'(exp_w_pc.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
# stack_seq

Memory-stage stack sequencer that executes the multi-cycle stack work the control unit requests: pushes PC/flags on CALL and interrupt, pops them on RET/RTI, and fetches the interrupt vector. It owns the stack pointer, drives the data-memory port while active, and raises `Busy` so upstream stages stall until it hands a new PC back to fetch.

## Interface
Parameters:
- `AW`, 11, data-memory word-address width; SP and `MemAddr` are `AW` bits.
- `SP_RESET`, 2**AW-1, stack-pointer value after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `INT`  in  1  interrupt request pulse.
- `Call`  in  1  CALL request pulse; `PcIn` = return address, `CallTarget` = target.
- `Ret`  in  1  RET request pulse.
- `Rti`  in  1  RTI request pulse.
- `PcIn`  in  32  PC to push.
- `CallTarget`  in  32  CALL destination.
- `FlagsIn`  in  3  CCR {C,N,Z} to push.
- `MemRdData`  in  16  memory read data, valid one cycle after `MemRE`.
- `MemAddr`  out  AW  memory address.
- `MemWrData`  out  16  memory write data.
- `MemWE`  out  1  memory write enable.
- `MemRE`  out  1  memory read enable.
- `Busy`  out  1  high whenever state != IDLE.
- `PcOut`  out  32  new PC; valid while `PcLoad` is high.
- `PcLoad`  out  1  one-cycle pulse.
- `FlagsOut`  out  3  restored flags; valid while `FlagsLoad` is high.
- `FlagsLoad`  out  1  one-cycle pulse (RTI only).
- `SP`  out  AW  current stack pointer.

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_F, VEC_H, VEC_L, POP_F, POP_L, POP_H, FIN.
- Requests are sampled only in IDLE. Priority: INT > Call > Rti > Ret. Lower-priority requests arriving in the same cycle are dropped.
- Accept latches `PcIn`, `FlagsIn`, `CallTarget` and the request kind.
- Push (post-decrement): write at SP, then SP <= SP-1.
  - PUSH_H writes PC[31:16].
  - PUSH_L writes PC[15:0].
  - PUSH_F writes {13'b0, flags}.
- Pop (pre-increment): read at SP+1, then SP <= SP+1.
- INT path: PUSH_H, PUSH_L, PUSH_F, VEC_H, VEC_L, FIN.
  - VEC_H reads addr 0.
  - VEC_L reads addr 1 and captures the high word.
  - FIN captures the low word and pulses `PcLoad` with `PcOut` = {mem[0], mem[1]}.
- Call path: PUSH_H, PUSH_L, FIN. FIN pulses `PcLoad` with `PcOut` = latched `CallTarget`.
- Ret path: POP_L, POP_H, FIN.
  - POP_H captures the low word.
  - FIN captures the high word and pulses `PcLoad`.
- Rti path: POP_F, POP_L, POP_H, FIN.
  - POP_L captures `FlagsOut` from `MemRdData[2:0]`.
  - FIN pulses both `PcLoad` and `FlagsLoad`.
- FIN always returns to IDLE.
- Pending interrupt: INT seen while not IDLE sets a pending flag. Pending is treated as INT in IDLE and cleared on accept. Call/Ret/Rti while busy are ignored (upstream stalls on `Busy`).
- SP arithmetic is modulo 2**AW: 0 decrements to 2**AW-1, 2**AW-1 increments to 0. No overflow flag.
- `MemWE` and `MemRE` are never high together. Both are 0 in IDLE and FIN.

## Timing
- Reset values: state IDLE, SP = `SP_RESET`, pending 0, all outputs 0 except `SP`.
- Reset mid-sequence: abort on that edge; no further memory access, no `PcLoad`/`FlagsLoad`. SP is restored to `SP_RESET`.
- Request accepted at edge N:
  - `Busy` goes high after edge N.
  - The first memory access is in cycle N+1.
- Cycle counts from accept to the `PcLoad` cycle: INT 6, Call 3, Ret 3, Rti 4.
- `Busy` falls the cycle after FIN. A pending INT is accepted on that IDLE cycle's edge, so there is exactly one IDLE cycle between sequences.
- Memory outputs are registered-state decodes, stable for the whole cycle.

## Test plan
- After reset, Call with `PcIn`=0x0001_2345 and `CallTarget`=0x0000_0100:
  - mem[2047]=0x0001, mem[2046]=0x2345.
  - SP=2045.
  - `PcLoad` with 0x100 in the 3rd cycle.
- Then Ret: reads 2046 then 2047, SP=2047, `PcOut`=0x0001_2345, `FlagsLoad` stays 0.
- INT with `PcIn`=0x10, `FlagsIn`=3'b101, mem[0]=0x0000, mem[1]=0x0200:
  - pushes 0x0000, 0x0010, 0x0005 at 2047..2045.
  - SP=2044, `PcOut`=0x200.
  - Followed by Rti: `FlagsOut`=3'b101, `PcOut`=0x10, SP=2047.
- INT and Call in the same IDLE cycle: only the INT sequence runs; no CallTarget load.
- INT pulse in the 2nd cycle of a Call: Call completes, one IDLE cycle, then the INT sequence pushes `CallTarget`-side PC as presented. Pending clears.
- SP wrap with `SP_RESET`=0: Call writes addr 0 then 2047, SP=2046. `rst` asserted during PUSH_L of another Call: no further `MemWE`, SP=`SP_RESET`, `Busy`=0 next cycle.
